mem_arbiter: RTL

Two-port arbiter that shares the single unified memory between the fetch stage and the load/store (data) path. It accepts one request per cycle from either requester. It issues that request on the memory port, tracks the outstanding read for a fixed memory latency, and routes the read data back to the owner. It sits between `fetch`/the future memory stage and `memory`, replacing the direct `pc -> addr_i` tie-off.

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch (IF) and data (DM) share one fixed-latency memory port.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin conflict resolution (default: DM wins).
module mem_arbiter #(
  parameter int unsigned AWIDTH      = 32,
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [AWIDTH-1:0] dm_addr_i,
  input  logic [DWIDTH-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DWIDTH-1:0] dm_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LatCnt = CW'(MEM_LATENCY);
  localparam logic [CW-1:0] OneCnt = CW'(1);

  typedef enum logic {StIdle, StBusy} state_e;
  typedef enum logic {OwnIf, OwnDm} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic rsp_due;
  logic issue_ok;
  logic pick_dm;
  logic grant_if;
  logic grant_dm;
  logic issue_read;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;
`endif

  // Final BUSY cycle: read data is on mem_rdata_i and the port may be reused.
  assign rsp_due  = (state_q == StBusy) && (cnt_q == LatCnt);
  assign issue_ok = (state_q == StIdle) || rsp_due;

  always_comb begin
    pick_dm = 1'b0;
    if (dm_req_i && !if_req_i) begin
      pick_dm = 1'b1;
    end else if (dm_req_i && if_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_dm = (last_q == OwnIf);
`else
      pick_dm = 1'b1;
`endif
    end
  end

  // Grants are suppressed while reset is held so every output reads 0.
  assign grant_dm   = !rst && issue_ok && dm_req_i && pick_dm;
  assign grant_if   = !rst && issue_ok && if_req_i && !pick_dm;
  assign issue_read = grant_if || (grant_dm && !dm_we_i);

  always_comb begin
    if_gnt_o       = grant_if;
    dm_gnt_o       = grant_dm;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if (grant_if) begin
      mem_addr_o    = if_addr_i;
      mem_read_en_o = 1'b1;
    end else if (grant_dm) begin
      mem_addr_o = dm_addr_i;
      if (dm_we_i) begin
        mem_wdata_o    = dm_wdata_i;
        mem_write_en_o = 1'b1;
      end else begin
        mem_read_en_o = 1'b1;
      end
    end
  end

  always_comb begin
    if_rvalid_o = 1'b0;
    dm_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_rdata_o  = '0;
    if (rsp_due && !rst) begin
      if (owner_q == OwnIf) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end else begin
        dm_rvalid_o = 1'b1;
        dm_rdata_o  = mem_rdata_i;
      end
    end
  end

  assign busy_o = (state_q == StBusy);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (issue_read) begin
          state_d = StBusy;
          owner_d = grant_dm ? OwnDm : OwnIf;
          cnt_d   = OneCnt;
        end
      end
      StBusy: begin
        if (!rsp_due) begin
          cnt_d = cnt_q + OneCnt;
        end else if (issue_read) begin
          owner_d = grant_dm ? OwnDm : OwnIf;
          cnt_d   = OneCnt;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (grant_if) begin
      last_d = OwnIf;
    end else if (grant_dm) begin
      last_d = OwnDm;
    end
  end

  // Reset to "DM granted last" so IF wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OwnDm;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
